// File: rtl/vec_mem_sequencer.sv
// Vector memory sequencer: serialises a LANES x 8-bit vector load or store
// into one byte-wide data-memory access per cycle, stalling the pipeline
// front end while busy and pulsing done once the vector is complete.
module vec_mem_sequencer #(
   parameter int LANES  = 6,
   parameter int STRIDE = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               isStore,
   input  logic [15:0]        baseAddr,
   input  logic [8*LANES-1:0] storeData,
   input  logic [7:0]         memRdData,
   output logic [15:0]        memAddr,
   output logic               memWe,
   output logic               memRe,
   output logic [7:0]         memWrData,
   output logic [8*LANES-1:0] loadData,
   output logic               stall,
   output logic               done
);

   localparam int W  = 8 * LANES;
   localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [2:0] {
      IDLE,
      STORE,
      LOAD,
      LWAIT,
      DONE
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [CW-1:0]   lane;
   logic [15:0]     base_q;
   logic [W-1:0]    data_q;

   // Read data returns one cycle after memRe, so remember which lane it belongs to.
   logic            rd_valid;
   logic [CW-1:0]   rd_lane;

   logic            last_lane;
   logic            accept;
   logic [15:0]     lane_addr;
   logic [7:0]      lane_byte;

   assign last_lane = (lane == CW'(LANES - 1));
   assign accept    = (state == IDLE) && start;
   // Address wraps naturally modulo 2^16 through the 16-bit truncation.
   assign lane_addr = base_q + 16'(int'(lane) * STRIDE);
   assign lane_byte = data_q[lane*8 +: 8];

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; blocking here would create ordering races.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and memory-port decode; reset forces every output quiet.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves a
      // signal unassigned, which would otherwise infer a latch.
      state_nxt = state;
      memWe     = 1'b0;
      memRe     = 1'b0;
      memAddr   = 16'h0000;
      memWrData = 8'h00;
      stall     = 1'b0;
      done      = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               stall     = 1'b1;
               state_nxt = isStore ? STORE : LOAD;
            end
         end
         STORE: begin
            stall     = 1'b1;
            memWe     = 1'b1;
            memAddr   = lane_addr;
            memWrData = lane_byte;
            if (last_lane) state_nxt = DONE;
         end
         LOAD: begin
            stall   = 1'b1;
            memRe   = 1'b1;
            memAddr = lane_addr;
            if (last_lane) state_nxt = LWAIT;
         end
         LWAIT: begin
            stall     = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if (rst) begin
         memWe     = 1'b0;
         memRe     = 1'b0;
         memAddr   = 16'h0000;
         memWrData = 8'h00;
         stall     = 1'b0;
         done      = 1'b0;
      end
   end

   // Operand latch, lane counter and load-vector assembly.
   always_ff @(posedge clk) begin
      if (rst) begin
         lane     <= '0;
         base_q   <= '0;
         data_q   <= '0;
         rd_valid <= 1'b0;
         rd_lane  <= '0;
         loadData <= '0;
      end else begin
         rd_valid <= memRe;
         rd_lane  <= lane;
         if (rd_valid) loadData[rd_lane*8 +: 8] <= memRdData;

         if (accept) begin
            base_q <= baseAddr;
            data_q <= storeData;
            lane   <= '0;
         end else if (memWe || memRe) begin
            lane <= last_lane ? '0 : lane + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer: directed scenarios plus random
// loads/stores against a byte-array reference model of memory and loadData.
module tb_vec_mem_sequencer;

   localparam int LANES  = 6;
   localparam int STRIDE = 1;
   localparam int W      = 8 * LANES;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           isStore = 1'b0;
   logic [15:0]    baseAddr = '0;
   logic [W-1:0]   storeData = '0;
   logic [7:0]     memRdData = '0;
   logic [15:0]    memAddr;
   logic           memWe;
   logic           memRe;
   logic [7:0]     memWrData;
   logic [W-1:0]   loadData;
   logic           stall;
   logic           done;

   int checks = 0;
   int passed = 0;

   // Environment memory (written by the DUT) and the reference model's view.
   logic [7:0]     mem     [65536];
   logic [7:0]     ref_mem [65536];
   logic [W-1:0]   ref_load = '0;

   vec_mem_sequencer #(.LANES(LANES), .STRIDE(STRIDE)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .isStore   (isStore),
      .baseAddr  (baseAddr),
      .storeData (storeData),
      .memRdData (memRdData),
      .memAddr   (memAddr),
      .memWe     (memWe),
      .memRe     (memRe),
      .memWrData (memWrData),
      .loadData  (loadData),
      .stall     (stall),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Synchronous data memory: read data valid the cycle after memRe.
   always @(posedge clk) begin
      memRdData <= memRe ? mem[memAddr] : 8'h00;
      if (memWe) mem[memAddr] <= memWrData;
   end

   // Run one operation starting in the current cycle (cycle 0) and check every
   // cycle up to and including the done cycle against the timing rules.
   task automatic run_op(input logic st, input logic [15:0] base,
                         input logic [W-1:0] data, input logic hold,
                         input string tag);
      int           last_c;
      logic [27:0]  obs;
      logic [27:0]  exp;
      logic         e_we, e_re, e_stall, e_done;
      logic [15:0]  e_addr;
      logic [7:0]   e_wd;
      logic [W-1:0] exp_load;
      logic [W-1:0] got_mem;
      logic [15:0]  a;

      // Reference model: loads take memory bytes, stores update memory.
      if (!st) begin
         for (int i = 0; i < LANES; i++) begin
            a = base + 16'(i * STRIDE);
            ref_load[i*8 +: 8] = ref_mem[a];
         end
      end else begin
         for (int i = 0; i < LANES; i++) begin
            a = base + 16'(i * STRIDE);
            ref_mem[a] = data[i*8 +: 8];
         end
      end
      exp_load = ref_load;

      last_c    = st ? LANES + 1 : LANES + 2;
      start     = 1'b1;
      isStore   = st;
      baseAddr  = base;
      storeData = data;

      for (int c = 0; c <= last_c; c++) begin
         @(negedge clk);
         e_we = 1'b0; e_re = 1'b0; e_addr = 16'h0; e_wd = 8'h0;
         e_stall = 1'b0; e_done = 1'b0;
         if (c == 0) begin
            e_stall = 1'b1;
         end else if (c <= LANES) begin
            e_stall = 1'b1;
            e_addr  = base + 16'((c - 1) * STRIDE);
            if (st) begin
               e_we = 1'b1;
               e_wd = data[(c-1)*8 +: 8];
            end else begin
               e_re = 1'b1;
            end
         end else if (c == last_c) begin
            e_done = 1'b1;
         end else begin
            e_stall = 1'b1;
         end
         exp = {e_we, e_re, e_addr, e_wd, e_stall, e_done};
         obs = {memWe, memRe, memAddr, memWrData, stall, done};
         checks++;
         if (obs !== exp)
            $display("FAIL %s cycle %0d {we,re,addr,wd,stall,done}: got %h expected %h",
                     tag, c, obs, exp);
         else passed++;

         if (c == last_c) begin
            checks++;
            if (loadData !== exp_load)
               $display("FAIL %s loadData: got %h expected %h", tag, loadData, exp_load);
            else passed++;
            if (st) begin
               for (int i = 0; i < LANES; i++) begin
                  a = base + 16'(i * STRIDE);
                  got_mem[i*8 +: 8] = mem[a];
               end
               checks++;
               if (got_mem !== data)
                  $display("FAIL %s memory contents: got %h expected %h", tag, got_mem, data);
               else passed++;
            end
         end

         @(posedge clk);
         #1;
         if (!hold) start = 1'b0;
         isStore   = 1'($urandom);
         baseAddr  = 16'($urandom);
         storeData = W'({$urandom(), $urandom()});
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if ({memWe, memRe, memAddr, memWrData, stall, done} !== 28'h0)
            $display("FAIL reset outputs: got %h expected 0",
                     {memWe, memRe, memAddr, memWrData, stall, done});
         else passed++;
         checks++;
         if (loadData !== '0)
            $display("FAIL reset loadData: got %h expected 0", loadData);
         else passed++;
      end
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      ref_load = '0;
      @(negedge clk);
      checks++;
      if ({stall, done, memWe, memRe} !== 4'b0000)
         $display("FAIL idle after reset: got %b expected 0000", {stall, done, memWe, memRe});
      else passed++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_store();
      run_op(1'b1, 16'h0010, 48'h060504030201, 1'b0, "store");
   endtask

   task automatic test_load();
      logic [7:0] pat [6];
      pat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
      for (int i = 0; i < 6; i++) begin
         mem[16'h0020 + 16'(i)]     = pat[i];
         ref_mem[16'h0020 + 16'(i)] = pat[i];
      end
      run_op(1'b0, 16'h0020, '0, 1'b0, "load");
      checks++;
      if (loadData !== 48'hFFEEDDCCBBAA)
         $display("FAIL load vector: got %h expected ffeeddccbbaa", loadData);
      else passed++;
   endtask

   task automatic test_wrap();
      run_op(1'b1, 16'hFFFE, 48'h665544332211, 1'b0, "wrap_store");
      run_op(1'b0, 16'hFFFD, '0, 1'b0, "wrap_load");
   endtask

   task automatic test_busy_start();
      run_op(1'b1, 16'h0100, 48'h0C0B0A090807, 1'b1, "busy_first");
      run_op(1'b1, 16'h0200, 48'h1211100F0E0D, 1'b0, "busy_second");
   endtask

   task automatic test_back_to_back();
      run_op(1'b0, 16'h0010, '0, 1'b0, "b2b_load");
      run_op(1'b1, 16'h0300, 48'hDEADBEEFCAFE, 1'b0, "b2b_store");
   endtask

   task automatic test_random();
      logic [15:0] b;
      for (int n = 0; n < 10; n++) begin
         b = (n % 3 == 0) ? 16'hFFFF - 16'($urandom_range(0, 4)) : 16'($urandom);
         run_op(1'($urandom), b, W'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)), "random");
      end
      // Settle into IDLE in case the last random op held start high.
      start = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_load();
      start    = 1'b1;
      isStore  = 1'b0;
      baseAddr = 16'h0040;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({memWe, memRe, stall, done} !== 4'b0000)
         $display("FAIL mid_load reset cycle: got %b expected 0000", {memWe, memRe, stall, done});
      else passed++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ref_load = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if ({memWe, memRe, done} !== 3'b000)
            $display("FAIL mid_load after reset cycle %0d: got %b expected 000",
                     c, {memWe, memRe, done});
         else passed++;
      end
      checks++;
      if (loadData !== '0)
         $display("FAIL mid_load loadData: got %h expected 0", loadData);
      else passed++;
      @(posedge clk);
      #1;
      run_op(1'b0, 16'h0040, '0, 1'b0, "post_reset_load");
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      test_reset();
      test_store();
      test_load();
      test_wrap();
      test_busy_start();
      test_back_to_back();
      test_random();
      test_reset_mid_load();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/vec_mem_sequencer.md
VEC_MEM_SEQUENCER -- requirements
Module: vec_mem_sequencer

Interface
REQ-001 Parameter: LANES, default 6, number of 8-bit vector lanes; vector width W = 8*LANES (48 by default).
REQ-002 Parameter: STRIDE, default 1, byte address increment between consecutive lanes.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: start  input  1  vector memory op requested by pipeline; sampled only in IDLE.
REQ-006 Port: isStore  input  1  1 = vector store, 0 = vector load; sampled with start.
REQ-007 Port: baseAddr  input  16  byte address of lane 0; sampled with start.
REQ-008 Port: storeData  input  W  store vector, lane i = bits [8i+7:8i]; sampled with start.
REQ-009 Port: memRdData  input  8  data memory read byte, valid the cycle after memRe.
REQ-010 Port: memAddr  output  16  data memory byte address.
REQ-011 Port: memWe  output  1  data memory write enable.
REQ-012 Port: memRe  output  1  data memory read enable.
REQ-013 Port: memWrData  output  8  data memory write byte.
REQ-014 Port: loadData  output  W  assembled load vector, lane i = bits [8i+7:8i].
REQ-015 Port: stall  output  1  freezes fetch/decode while the sequencer is busy.
REQ-016 Port: done  output  1  single-cycle completion pulse.

Function
REQ-017 States SHALL be IDLE, STORE, LOAD, LWAIT and DONE, with a lane counter of ceil(log2(LANES)) bits.
REQ-018 IDLE: start=1 SHALL latch isStore, baseAddr and storeData, clear the lane counter, and go to STORE or LOAD; start=0 SHALL hold IDLE.
REQ-019 STORE: each cycle SHALL drive memWe=1, memAddr=latched base+i*STRIDE and memWrData=lane i, then increment i; after lane LANES-1 it SHALL go to DONE.
REQ-020 LOAD: each cycle SHALL drive memRe=1 and memAddr=base+i*STRIDE, then increment i; after lane LANES-1 it SHALL go to LWAIT.
REQ-021 In the cycle after each read (LOAD cycles 2..LANES and LWAIT), memRdData SHALL be captured into loadData lane i-1 at the clock edge.
REQ-022 LWAIT SHALL issue no access, capture the last lane and go to DONE.
REQ-023 DONE SHALL assert done=1 for exactly one cycle and return to IDLE.
REQ-024 Latency, with start accepted in cycle 0: a store SHALL write in cycles 1..LANES with done in cycle LANES+1 (7 by default); a load SHALL read in cycles 1..LANES with done in cycle LANES+2 (8 by default).
REQ-025 stall SHALL be combinational: 1 in IDLE when start=1, 1 in STORE, LOAD and LWAIT, and 0 in IDLE with start=0 and in DONE.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 In DONE, start=1 SHALL NOT be accepted; it is accepted in the following IDLE cycle.
REQ-028 Address arithmetic SHALL be modulo 2^16; base 0xFFFF with STRIDE 1 wraps to 0x0000.
REQ-029 memWe and memRe SHALL never both be 1.
REQ-030 When no access is issued, memAddr and memWrData SHALL be 0.
REQ-031 loadData SHALL hold its value from the end of a load until the next load overwrites its lanes; stores SHALL NOT modify it.

Reset
REQ-032 With rst=1 at a clock edge, the next state SHALL be IDLE, the lane counter 0 and loadData 0.
REQ-033 While in reset, memWe, memRe, done and stall SHALL be 0 and memAddr and memWrData SHALL be 0, regardless of start.
REQ-034 rst asserted mid-operation SHALL abort it with no further memory access and no done pulse.

Verification
REQ-035 Store: start, isStore=1, base 0x0010, storeData 0x060504030201 -> writes 01..06 to 0x0010..0x0015 in cycles 1..6; done in cycle 7; stall 1 in cycles 0..6, 0 in cycle 7.
REQ-036 Load: memory 0x0020..0x0025 = AA,BB,CC,DD,EE,FF; start, isStore=0 -> memRe in cycles 1..6; done in cycle 8 with loadData 0xFFEEDDCCBBAA.
REQ-037 Wrap: store with base 0xFFFE -> memAddr sequence FFFE, FFFF, 0000, 0001, 0002, 0003.
REQ-038 Busy start: start held high throughout a store -> first op completes unaltered; second op accepted in the IDLE cycle after DONE.
REQ-039 Reset mid-load: rst in cycle 3 -> memRe=0 from the next cycle; done never pulses; loadData=0.
REQ-040 Back-to-back: load then store -> loadData unchanged by the store; memWe and memRe never both 1.
